csa_add_sequencer: RTL and testbench
====================================

# csa_add_sequencer

Multi-cycle wide-operand adder built around one shared 8-bit carry-select adder core. Arbitrates round-robin between NUM_REQ requesters, then streams each accepted operand pair through the core one byte per cycle, LSB first, chaining the carry in a register. Returns a full-width sum and carry-out on a single valid/ready response port. Sits between the approximate-adder experiment harness and the 8-bit adder core, so wide additions share one adder instance.

## Interface
- NUM_REQ, 2: number of requesters (≥2).
- WORDS, 4: operand width in bytes; W = 8*WORDS.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a, req_b  in  NUM_REQ×W  per-requester operands.
- req_cin  in  NUM_REQ  per-requester carry-in.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester owning the result.
- rsp_sum  out  W  sum.
- rsp_cout  out  1  carry-out of bit W-1.
- rsp_ovf  out  1  signed overflow (present only with CSA_SEQ_OVF_EN).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when any req_valid is high, grant one requester by round-robin. Assert its req_ready combinationally in that cycle. Capture a, b, cin and id. Clear byte index. Go to RUN.
- Round-robin: the requester after the last grant has highest priority. After reset, requester 0 has highest priority.
- RUN: each cycle, feed byte k of a/b and the carry register to the core. Write the core sum to byte k of the sum register and the core cout to the carry register. Increment k. After byte WORDS-1, go to DONE.
- DONE: rsp_valid=1. rsp_sum, rsp_cout and rsp_id stay stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. No request is accepted outside IDLE.
- Arithmetic: exact unsigned modulo-2^W sum of a+b+cin. rsp_cout is the final carry register.
- Reset at any point: state returns to IDLE and any in-flight transaction is discarded with no response. Round-robin pointer returns to requester 0.
- req_valid dropping in RUN/DONE has no effect; captured operands are used.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
- Accept at cycle T (IDLE with valid). Byte k is computed in cycle T+1+k. rsp_valid rises in cycle T+WORDS+1.
- Response consumed in cycle R means IDLE in R+1. The earliest next accept is R+1. Throughput is one operation per WORDS+2 cycles with rsp_ready tied high.
- Core path is combinational within one cycle: register to core to register.

## Configuration
- CSA_SEQ_OVF_EN defined: adds rsp_ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]). It is registered at the end of RUN and held with the result in DONE.
- Not defined: port rsp_ovf and its logic are absent. All other behaviour is identical.

## Structure
- Package csa_seq_pkg: BYTE_W=8 constant and the state enum type (IDLE, RUN, DONE).
- Sub-module rr_arbiter (parameter NUM_REQ): inputs are request vector, enable and pointer update. Output is a one-hot grant. It holds the priority pointer.
- Instantiates one carry_select_adder_8bit as the byte core.

## Test plan
All scenarios use NUM_REQ=2, WORDS=4.
- Reset check: assert rst for 2 cycles. All outputs are at their reset values and the state is IDLE.
- Ripple across bytes: req0 sends a=0x000000FF, b=0x00000001, cin=0. Required: rsp_sum=0x00000100, rsp_cout=0, rsp_id=0, rsp_valid exactly 5 cycles after accept.
- Full wrap: a=0xFFFFFFFF, b=0x00000000, cin=1. Required: rsp_sum=0x00000000, rsp_cout=1.
- Arbitration: after reset, both requesters are valid continuously with rsp_ready=1. Grant order must be 0, 1, 0, 1, with req_ready one-hot and only in IDLE.
- Backpressure: hold rsp_ready=0 for 10 cycles while req1 is valid. Result stays stable, req_ready stays 0, and req1 is accepted in the cycle after the handshake.
- Reset mid-RUN plus overflow: assert rst at byte 2. No rsp_valid follows and req0 regains priority. With CSA_SEQ_OVF_EN, 0x7FFFFFFF+0x00000001 gives sum 0x80000000, rsp_ovf=1, rsp_cout=0.

Source files
------------

// File: rtl/csa_seq_pkg.sv
// Shared constants and FSM state type for the wide-operand adder sequencer.
// Optional overflow flag enabled by defining CSA_SEQ_OVF_EN.
package csa_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/csa_add_sequencer_if.sv
// Request/response bundle between requesters and the adder sequencer.
// rsp_ovf exists only when CSA_SEQ_OVF_EN is defined.
interface csa_add_sequencer_if
    import csa_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WORDS   = 4
);
    localparam int W   = BYTE_W * WORDS;
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][W-1:0] req_a;
    logic [NUM_REQ-1:0][W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_cin;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IDW-1:0]            rsp_id;
    logic [W-1:0]              rsp_sum;
    logic                      rsp_cout;
`ifdef CSA_SEQ_OVF_EN
    logic                      rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`endif

endinterface

// File: rtl/carry_select_adder_8bit.sv
// 8-bit carry-select adder: low nibble ripples, high nibble precomputed
// for both carries and selected by the low nibble's carry-out.
module carry_select_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = hi0 + 5'd1;

    assign sum[3:0]          = lo[3:0];
    assign {cout, sum[7:4]}  = lo[4] ? hi1 : hi0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the pointer names the requester
// with highest priority and moves past the winner on upd.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               upd,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] sel;

    // Prefer requests at or above the pointer, else wrap to the lowest one.
    assign mask = ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
    assign hi   = req & mask;
    assign sel  = (|hi) ? hi : req;
    assign gnt  = en ? (sel & (~sel + NUM_REQ'(1))) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/csa_add_sequencer.sv
// Streams wide additions through one 8-bit carry-select core, LSB byte first.
// Define CSA_SEQ_OVF_EN to add the registered signed-overflow flag.
module csa_add_sequencer
    import csa_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WORDS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    csa_add_sequencer_if.slave bus
);
    localparam int W   = BYTE_W * WORDS;
    localparam int IDW = $clog2(NUM_REQ);
    localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_e         state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NUM_REQ-1:0] gnt;
    logic               arb_en;
    logic               accept;
    logic [BYTE_W-1:0]  core_a;
    logic [BYTE_W-1:0]  core_b;
    logic [BYTE_W-1:0]  core_s;
    logic               core_co;
`ifdef CSA_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    assign arb_en = (state_q == IDLE) && !rst;
    assign accept = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  (arb_en),
        .upd (accept),
        .gnt (gnt)
    );

    assign core_a = a_q[{k_q, 3'b000} +: BYTE_W];
    assign core_b = b_q[{k_q, 3'b000} +: BYTE_W];

    carry_select_adder_8bit u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (carry_q),
        .sum  (core_s),
        .cout (core_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        k_d     = k_q;
`ifdef CSA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            a_d     = bus.req_a[i];
                            b_d     = bus.req_b[i];
                            carry_d = bus.req_cin[i];
                            id_d    = IDW'(i);
                        end
                    end
                    k_d     = '0;
                    state_d = RUN;
`ifdef CSA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d[{k_q, 3'b000} +: BYTE_W] = core_s;
                carry_d = core_co;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(WORDS - 1)) begin
                    state_d = DONE;
`ifdef CSA_SEQ_OVF_EN
                    ovf_d = (a_q[W-1] == b_q[W-1]) &&
                            (core_s[BYTE_W-1] != a_q[W-1]);
`endif
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
            k_q     <= '0;
`ifdef CSA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            k_q     <= k_d;
`ifdef CSA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = carry_q;
`ifdef CSA_SEQ_OVF_EN
    assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_csa_add_sequencer.sv
// Scoreboard bench for csa_add_sequencer (NUM_REQ=2, WORDS=4); checks
// rsp_ovf when CSA_SEQ_OVF_EN is defined.
module tb_csa_add_sequencer;

    localparam int NR = 2;
    localparam int WD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_add_sequencer_if #(.NUM_REQ(NR), .WORDS(WD)) bus ();

    csa_add_sequencer #(.NUM_REQ(NR), .WORDS(WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ptr   = 0;
    bit   busy  = 1'b0;
    bit   prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: wide integer arithmetic, signed overflow from range check.
    function automatic exp_t model(int id, logic [31:0] a, logic [31:0] b,
                                   logic cin, int acc);
        exp_t e;
        longint unsigned u;
        longint s;
        u = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        s = longint'($signed(a)) + longint'($signed(b)) + longint'({63'd0, cin});
        e.id   = id;
        e.sum  = u[31:0];
        e.cout = u[32];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: predicts grants, pushes expectations, pops on response.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            busy   = 1'b0;
            ptr    = 0;
            prev_v = 1'b0;
        end else begin
            if (busy) begin
                chk("ready_while_busy", {62'd0, bus.req_ready}, 64'd0);
            end else if (|bus.req_valid) begin
                int eidx;
                int aidx;
                eidx = -1;
                aidx = -1;
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (ptr + k) % NR;
                    if (eidx < 0 && bus.req_valid[idx]) eidx = idx;
                end
                chk("grant", {62'd0, bus.req_ready}, 64'd1 << eidx);
                for (int k = 0; k < NR; k++) begin
                    if (bus.req_ready[k] && aidx < 0) aidx = k;
                end
                if (aidx >= 0) begin
                    sb.push_back(model(aidx, bus.req_a[aidx], bus.req_b[aidx],
                                       bus.req_cin[aidx], cyc));
                    busy = 1'b1;
                    ptr  = (aidx + 1) % NR;
                end
            end else begin
                chk("idle_no_ready", {62'd0, bus.req_ready}, 64'd0);
            end

            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb[0];
                    chk("rsp_id", {63'd0, bus.rsp_id}, 64'(e.id));
                    chk("rsp_sum", {32'd0, bus.rsp_sum}, {32'd0, e.sum});
                    chk("rsp_cout", {63'd0, bus.rsp_cout}, {63'd0, e.cout});
`ifdef CSA_SEQ_OVF_EN
                    chk("rsp_ovf", {63'd0, bus.rsp_ovf}, {63'd0, e.ovf});
`endif
                    if (!prev_v) chk("latency", 64'(cyc - e.acc), 64'd5);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            prev_v = bus.rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic send(int i, logic [31:0] a, logic [31:0] b, logic c);
        bit ok;
        ok = 1'b0;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
        bus.req_cin[i]   = c;
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[i]) ok = 1'b1;
        end
        if (!ok) chk("send_timeout", {63'd0, bus.req_ready[i]}, 64'd1);
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 80 && (busy || sb.size() != 0); n++) begin
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", {63'd0, busy}, 64'd0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[4];
        int ord[4];
        bit ok;
        ord = '{0, 1, 0, 1};
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
        chk("rst_rsp_sum", {32'd0, bus.rsp_sum}, 64'd0);
        chk("rst_rsp_cout", {63'd0, bus.rsp_cout}, 64'd0);
`ifdef CSA_SEQ_OVF_EN
        chk("rst_rsp_ovf", {63'd0, bus.rsp_ovf}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: byte ripple, full wrap, signed overflow
        send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_idle();
        send(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_idle();
        send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_idle();

        // Arbitration after reset with both requesters always valid
        do_reset();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i]   = rnd_op();
            bus.req_b[i]   = rnd_op();
            bus.req_cin[i] = 1'($urandom_range(0, 1));
        end
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            got[g] = -1;
            for (int n = 0; n < 40 && !ok; n++) begin
                @(negedge clk);
                if (|bus.req_ready) begin
                    ok = 1'b1;
                    got[g] = bus.req_ready[1] ? 1 : 0;
                end
            end
            chk($sformatf("arb_order_%0d", g), 64'(got[g]), 64'(ord[g]));
            tick();
            if (got[g] >= 0) begin
                bus.req_a[got[g]] = rnd_op();
                bus.req_b[got[g]] = rnd_op();
            end
        end
        bus.req_valid = '0;
        wait_idle();

        // Backpressure with req1 waiting
        bus.rsp_ready = 1'b0;
        send(0, $urandom, $urandom, 1'b1);
        bus.req_a[1]     = rnd_op();
        bus.req_b[1]     = rnd_op();
        bus.req_cin[1]   = 1'b0;
        bus.req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) ok = 1'b1;
        end
        chk("bp_rsp_seen", {63'd0, bus.rsp_valid}, 64'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_req_ready", {62'd0, bus.req_ready}, 64'd0);
            chk("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_accept", {62'd0, bus.req_ready}, 64'd2);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // Reset during byte 2: no response, pointer back to requester 0
        send(0, $urandom, $urandom, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_mid_prio", {62'd0, bus.req_ready}, 64'd1);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                bus.req_valid[i] = 1'($urandom_range(0, 1));
                bus.req_a[i]     = rnd_op();
                bus.req_b[i]     = rnd_op();
                bus.req_cin[i]   = 1'($urandom_range(0, 1));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
